// File: rtl/control_sequencer_if.sv
// control_sequencer_if -- bundle between the control sequencer and the datapath.
//
// Signals:
//   run, mem_rdy, ir        : datapath -> sequencer (run request, memory ready, IR contents)
//   PCout .. HIin           : sequencer -> datapath one-bit strobes
//   alu_op                  : ALU select (0 none, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 MUL, 6 DIV)
//   rout_sel, rin_sel       : one-hot register-file out/in enables (bit n = Rn)
//   busy, illegal           : sequencer status
//   instr_count             : completed-instruction counter
// Modports: master = sequencer side, slave = datapath side.
interface control_sequencer_if;
  logic        run;
  logic        mem_rdy;
  logic [31:0] ir;
  logic        PCout, Zlowout, Zhighout, MDRout;
  logic        MARin, MDRin, IRin, PCin, Yin, Zin;
  logic        IncPC, Read, LOin, HIin;
  logic [3:0]  alu_op;
  logic [15:0] rout_sel;
  logic [15:0] rin_sel;
  logic        busy;
  logic        illegal;
  logic [15:0] instr_count;

  modport master (
    input  run, mem_rdy, ir,
    output PCout, Zlowout, Zhighout, MDRout, MARin, MDRin, IRin, PCin, Yin, Zin,
           IncPC, Read, LOin, HIin, alu_op, rout_sel, rin_sel, busy, illegal,
           instr_count
  );

  modport slave (
    output run, mem_rdy, ir,
    input  PCout, Zlowout, Zhighout, MDRout, MARin, MDRin, IRin, PCin, Yin, Zin,
           IncPC, Read, LOin, HIin, alu_op, rout_sel, rin_sel, busy, illegal,
           instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer -- hardwired fetch/decode/execute control unit for a
// simple bus-based datapath. Fetch is T0..T2, register-register ALU
// instructions execute in T3..T5 (T6 for MUL/DIV).
//
// Ports:
//   clk : system clock, rising-edge active
//   clr : asynchronous active-low reset
//   bus : control_sequencer_if.master (run/mem_rdy/ir in; strobes, alu_op,
//         rout_sel/rin_sel, busy, illegal, instr_count out)
//
// Configuration macro: CTRL_SEQ_MULDIV_EN -- when defined, MUL (01111) and
// DIV (10000) are legal and use T6 to move the high product/remainder word.
module control_sequencer (
  input logic           clk,
  input logic           clr,
  control_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  state_t      state, state_nxt;
  logic        t1_wait, t1_wait_nxt;   // already spent one cycle in T1 waiting
  logic [15:0] count, count_nxt;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        unused_ir_bits;

  assign opcode = bus.ir[31:27];
  assign ra     = bus.ir[26:23];
  assign rb     = bus.ir[22:19];
  assign rc     = bus.ir[18:15];
  assign unused_ir_bits = ^bus.ir[14:0];

  // Opcode -> ALU select; zero means the opcode is not supported.
  function automatic logic [3:0] alu_sel(input logic [4:0] op);
    case (op)
      5'b00011: return 4'd1;
      5'b00100: return 4'd2;
      5'b00101: return 4'd3;
      5'b00110: return 4'd4;
`ifdef CTRL_SEQ_MULDIV_EN
      5'b01111: return 4'd5;
      5'b10000: return 4'd6;
`endif
      default:  return 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      t1_wait <= 1'b0;
      count   <= 16'd0;
    end else begin
      state   <= state_nxt;
      t1_wait <= t1_wait_nxt;
      count   <= count_nxt;
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.instr_count = count;

  always_comb begin
    state_nxt    = state;
    t1_wait_nxt  = t1_wait;
    count_nxt    = count;
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.PCin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.LOin     = 1'b0;
    bus.HIin     = 1'b0;
    bus.alu_op   = 4'd0;
    bus.rout_sel = 16'd0;
    bus.rin_sel  = 16'd0;
    bus.illegal  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.run) state_nxt = T0;
      end
      T0: begin
        bus.PCout   = 1'b1;
        bus.MARin   = 1'b1;
        bus.IncPC   = 1'b1;
        bus.Zin     = 1'b1;
        t1_wait_nxt = 1'b0;
        state_nxt   = T1;
      end
      T1: begin
        // Incremented PC is loaded once; later wait cycles only hold the read.
        bus.Zlowout = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        bus.PCin    = ~t1_wait;
        if (bus.mem_rdy) state_nxt = T2;
        else             t1_wait_nxt = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_nxt  = T3;
      end
      T3: begin
        if (alu_sel(opcode) != 4'd0) begin
          bus.rout_sel = 16'd1 << rb;
          bus.Yin      = 1'b1;
          state_nxt    = T4;
        end else begin
          bus.illegal = 1'b1;
          state_nxt   = bus.run ? T0 : IDLE;
        end
      end
      T4: begin
        bus.rout_sel = 16'd1 << rc;
        bus.Zin      = 1'b1;
        bus.alu_op   = alu_sel(opcode);
        state_nxt    = T5;
      end
      T5: begin
        bus.Zlowout = 1'b1;
`ifdef CTRL_SEQ_MULDIV_EN
        if (opcode == 5'b01111 || opcode == 5'b10000) begin
          bus.LOin  = 1'b1;
          state_nxt = T6;
        end else begin
          bus.rin_sel = 16'd1 << ra;
          count_nxt   = count + 16'd1;
          state_nxt   = bus.run ? T0 : IDLE;
        end
`else
        bus.rin_sel = 16'd1 << ra;
        count_nxt   = count + 16'd1;
        state_nxt   = bus.run ? T0 : IDLE;
`endif
      end
      T6: begin
`ifdef CTRL_SEQ_MULDIV_EN
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        count_nxt    = count + 16'd1;
        state_nxt    = bus.run ? T0 : IDLE;
`else
        state_nxt    = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer -- directed and randomized bench for control_sequencer
// with a cycle-level behavioural model of the instruction timeline.
// Honours CTRL_SEQ_MULDIV_EN the same way the design does.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if bus ();
  control_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model ----------------
  // m_ph: -1 when not executing, otherwise the cycle index Tn of the instruction.
  int          m_ph     = -1;
  bit          m_waited = 1'b0;
  logic [15:0] m_cnt    = 16'd0;

  typedef struct packed {
    logic [13:0] s;       // {PCout,Zlowout,Zhighout,MDRout,MARin,MDRin,IRin,PCin,Yin,Zin,IncPC,Read,LOin,HIin}
    logic [3:0]  alu;
    logic [15:0] rout;
    logic [15:0] rin;
    logic        busy;
    logic        ill;
  } exp_t;

  localparam int S_PCOUT = 13, S_ZLO = 12, S_ZHI = 11, S_MDROUT = 10, S_MARIN = 9,
                 S_MDRIN = 8, S_IRIN = 7, S_PCIN = 6, S_YIN = 5, S_ZIN = 4,
                 S_INCPC = 3, S_READ = 2, S_LOIN = 1, S_HIIN = 0;

  function automatic int m_alu(input logic [4:0] op);
    int code;
    code = 0;
    if (op == 5'd3) code = 1;
    if (op == 5'd4) code = 2;
    if (op == 5'd5) code = 3;
    if (op == 5'd6) code = 4;
`ifdef CTRL_SEQ_MULDIV_EN
    if (op == 5'd15) code = 5;
    if (op == 5'd16) code = 6;
`endif
    return code;
  endfunction

  function automatic int m_last(input logic [4:0] op);
    return (m_alu(op) >= 5) ? 6 : 5;
  endfunction

  function automatic exp_t model_out(input int ph, input bit waited, input logic [31:0] i);
    exp_t e;
    int ra, rb, rc;
    logic [4:0] op;
    op = i[31:27];
    ra = int'(i[26:23]);
    rb = int'(i[22:19]);
    rc = int'(i[18:15]);
    e = '0;
    e.busy = (ph >= 0);
    if (ph == 0) begin
      e.s[S_PCOUT] = 1'b1; e.s[S_MARIN] = 1'b1; e.s[S_INCPC] = 1'b1; e.s[S_ZIN] = 1'b1;
    end else if (ph == 1) begin
      e.s[S_ZLO] = 1'b1; e.s[S_READ] = 1'b1; e.s[S_MDRIN] = 1'b1; e.s[S_PCIN] = !waited;
    end else if (ph == 2) begin
      e.s[S_MDROUT] = 1'b1; e.s[S_IRIN] = 1'b1;
    end else if (ph == 3) begin
      if (m_alu(op) == 0) e.ill = 1'b1;
      else begin e.rout[rb] = 1'b1; e.s[S_YIN] = 1'b1; end
    end else if (ph == 4) begin
      e.rout[rc] = 1'b1; e.s[S_ZIN] = 1'b1; e.alu = 4'(m_alu(op));
    end else if (ph == 5) begin
      e.s[S_ZLO] = 1'b1;
      if (m_last(op) == 6) e.s[S_LOIN] = 1'b1;
      else e.rin[ra] = 1'b1;
    end else if (ph == 6) begin
      e.s[S_ZHI] = 1'b1; e.s[S_HIIN] = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_ph = -1; m_waited = 1'b0; m_cnt = 16'd0;
    end else begin
      if (m_ph == -1) begin
        if (bus.run) m_ph = 0;
      end else if (m_ph == 0) begin
        m_ph = 1; m_waited = 1'b0;
      end else if (m_ph == 1) begin
        if (bus.mem_rdy) m_ph = 2; else m_waited = 1'b1;
      end else if (m_ph == 2) begin
        m_ph = 3;
      end else if (m_ph == 3 && m_alu(bus.ir[31:27]) == 0) begin
        m_ph = bus.run ? 0 : -1;
      end else if (m_ph == m_last(bus.ir[31:27])) begin
        m_cnt = m_cnt + 16'd1;
        m_ph  = bus.run ? 0 : -1;
      end else begin
        m_ph = m_ph + 1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] strobes();
    return {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.MARin, bus.MDRin,
            bus.IRin, bus.PCin, bus.Yin, bus.Zin, bus.IncPC, bus.Read, bus.LOin, bus.HIin};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int drivers;
    e = model_out(m_ph, m_waited, bus.ir);
    chk("sb_strobes", 32'(strobes()), 32'(e.s));
    chk("sb_alu_op", 32'(bus.alu_op), 32'(e.alu));
    chk("sb_rout_sel", 32'(bus.rout_sel), 32'(e.rout));
    chk("sb_rin_sel", 32'(bus.rin_sel), 32'(e.rin));
    chk("sb_busy", 32'(bus.busy), 32'(e.busy));
    chk("sb_illegal", 32'(bus.illegal), 32'(e.ill));
    chk("sb_instr_count", 32'(bus.instr_count), 32'(m_cnt));
    drivers = int'(bus.PCout) + int'(bus.Zlowout) + int'(bus.Zhighout) + int'(bus.MDRout)
            + $countones(bus.rout_sel);
    chk("sb_bus_drivers_le1", 32'(drivers <= 1), 32'd1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (bus.busy && b < 40) begin tick(); b++; end
    chk("wait_idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  logic [4:0] ops [9] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd15, 5'd16, 5'd31, 5'd0, 5'd7};

  initial begin
    logic [15:0] c0;
    bus.run = 1'b0; bus.mem_rdy = 1'b0; bus.ir = 32'h0;
    ticks(2);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_count", 32'(bus.instr_count), 32'd0);
    chk("rst_strobes", 32'(strobes()), 32'd0);

    // AND R1,R2,R3
    bus.run = 1'b1; bus.mem_rdy = 1'b1; bus.ir = 32'h28918000;
    tick();
    chk("rst_hold_busy", 32'(bus.busy), 32'd0);
    clr = 1'b1;
    tick();
    chk("and_t0_pcout", 32'(bus.PCout), 32'd1);
    tick();
    chk("and_t1_pcin", 32'(bus.PCin), 32'd1);
    tick();
    chk("and_t2_irin", 32'(bus.IRin), 32'd1);
    tick();
    chk("and_t3_rout", 32'(bus.rout_sel), 32'h0004);
    tick();
    chk("and_t4_rout", 32'(bus.rout_sel), 32'h0008);
    chk("and_t4_alu", 32'(bus.alu_op), 32'd3);
    tick();
    chk("and_t5_rin", 32'(bus.rin_sel), 32'h0002);
    bus.run = 1'b0;
    tick();
    chk("and_count", 32'(bus.instr_count), 32'd1);
    chk("and_idle", 32'(bus.busy), 32'd0);

    // Fetch with three not-ready cycles
    bus.run = 1'b1; bus.mem_rdy = 1'b0; bus.ir = 32'h18918000;
    ticks(2);
    chk("wait_c1_pcin", 32'(bus.PCin), 32'd1);
    tick();
    chk("wait_c2_pcin", 32'(bus.PCin), 32'd0);
    tick();
    chk("wait_c3_pcin", 32'(bus.PCin), 32'd0);
    tick();
    chk("wait_c4_read", 32'(bus.Read), 32'd1);
    chk("wait_c4_pcin", 32'(bus.PCin), 32'd0);
    bus.mem_rdy = 1'b1;
    tick();
    chk("wait_t2_irin", 32'(bus.IRin), 32'd1);
    bus.run = 1'b0;
    wait_idle();
    chk("wait_count", 32'(bus.instr_count), 32'd2);

    // Unsupported opcode 11111
    bus.run = 1'b1; bus.ir = 32'hF8000000;
    ticks(4);
    chk("ill_pulse", 32'(bus.illegal), 32'd1);
    chk("ill_rin", 32'(bus.rin_sel), 32'd0);
    chk("ill_yin", 32'(bus.Yin), 32'd0);
    tick();
    chk("ill_next_t0", 32'(bus.PCout), 32'd1);
    chk("ill_pulse_end", 32'(bus.illegal), 32'd0);
    chk("ill_count", 32'(bus.instr_count), 32'd2);
    bus.run = 1'b0;
    wait_idle();

    // OR with run dropped in T3
    bus.run = 1'b1; bus.ir = 32'h30918000;
    ticks(4);
    bus.run = 1'b0;
    tick();
    chk("or_t4_alu", 32'(bus.alu_op), 32'd4);
    tick();
    chk("or_t5_rin", 32'(bus.rin_sel), 32'h0002);
    tick();
    chk("or_idle", 32'(bus.busy), 32'd0);
    chk("or_count", 32'(bus.instr_count), 32'd3);

    // MUL
    bus.run = 1'b1; bus.ir = 32'h78918000;
    ticks(4);
`ifdef CTRL_SEQ_MULDIV_EN
    chk("mul_t3_yin", 32'(bus.Yin), 32'd1);
    tick();
    chk("mul_t4_alu", 32'(bus.alu_op), 32'd5);
    tick();
    chk("mul_t5_loin", 32'(bus.LOin), 32'd1);
    bus.run = 1'b0;
    tick();
    chk("mul_t6_zhi", 32'(bus.Zhighout), 32'd1);
    chk("mul_t6_hiin", 32'(bus.HIin), 32'd1);
    tick();
    chk("mul_count", 32'(bus.instr_count), 32'd4);
    chk("mul_idle", 32'(bus.busy), 32'd0);
`else
    chk("mul_illegal", 32'(bus.illegal), 32'd1);
    bus.run = 1'b0;
    wait_idle();
    chk("mul_count", 32'(bus.instr_count), 32'd3);
`endif

    // Asynchronous reset in the middle of T4
    bus.run = 1'b1; bus.ir = 32'h28918000;
    ticks(5);
    chk("rst4_in_t4", 32'(bus.Zin), 32'd1);
    #1 clr = 1'b0;
    #1;
    chk("rst4_busy", 32'(bus.busy), 32'd0);
    chk("rst4_strobes", 32'(strobes()), 32'd0);
    chk("rst4_rout", 32'(bus.rout_sel), 32'd0);
    chk("rst4_alu", 32'(bus.alu_op), 32'd0);
    chk("rst4_count", 32'(bus.instr_count), 32'd0);
    tick();
    clr = 1'b1;
    tick();
    chk("rst4_restart_t0", 32'(bus.PCout), 32'd1);

    // Randomized traffic
    c0 = 16'd0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      bus.run     = ($urandom_range(0, 9) != 0);
      bus.mem_rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 5) == 0)
        bus.ir = {ops[$urandom_range(0, 8)], 27'($urandom)};
      clr = ($urandom_range(0, 299) != 0);
      if (bus.instr_count != c0) c0 = bus.instr_count;
    end
    clr = 1'b1;
    bus.run = 1'b0;
    ticks(12);
    chk("final_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: clr  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: run  input  1  high = keep fetching/executing; low = stop at next instruction boundary.
REQ-004 SHALL have port: mem_rdy  input  1  memory read data valid on Mdatain this cycle.
REQ-005 SHALL have port: ir  input  32  datapath IR contents: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-006 SHALL have ports: PCout, Zlowout, Zhighout, MDRout, MARin, MDRin, IRin, PCin, Yin, Zin, IncPC, Read, LOin, HIin  output  1 each  datapath strobes.
REQ-007 SHALL have port: alu_op  output  4  ALU select: 0 none, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 MUL, 6 DIV.
REQ-008 SHALL have ports: rout_sel, rin_sel  output  16 each  one-hot register-file out/in enables (bit n = Rn).
REQ-009 SHALL have ports: busy  output  1  state != IDLE; illegal  output  1  one-cycle pulse on unsupported opcode; instr_count  output  16  completed instructions.

Function
REQ-010 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6; all strobes decoded combinationally from state and ir only.
REQ-011 SHALL move IDLE->T0 on rising clk with run=1; otherwise SHALL remain in IDLE with all strobes 0.
REQ-012 SHALL, in T0, assert PCout, MARin, IncPC, Zin; next state T1.
REQ-013 SHALL, in T1, assert Zlowout, PCin, Read, MDRin; SHALL stay in T1 while mem_rdy=0, with PCin asserted only in the first T1 cycle; mem_rdy=1 -> T2.
REQ-014 SHALL, in T2, assert MDRout, IRin; next state T3.
REQ-015 SHALL decode ir[31:27] in T3: 00011 ADD, 00100 SUB, 00101 AND, 00110 OR; 01111 MUL and 10000 DIV only per REQ-025.
REQ-016 SHALL, in T3 with legal opcode, assert rout_sel[Rb] and Yin; next state T4.
REQ-017 SHALL, in T3 with illegal opcode, pulse illegal for that cycle, assert no other strobes, and go to T0 if run=1, else IDLE; instr_count SHALL NOT increment.
REQ-018 SHALL, in T4, assert rout_sel[Rc], Zin, and alu_op per opcode; next state T5.
REQ-019 SHALL, in T5 for ADD/SUB/AND/OR, assert Zlowout and rin_sel[Ra]; instruction then completes.
REQ-020 SHALL, on completion, increment instr_count by 1 (0xFFFF wraps to 0x0000) and go to T0 if run=1, else IDLE.
REQ-021 SHALL keep rout_sel and rin_sel one-hot in their active states and all-zero otherwise; at most one of PCout, Zlowout, Zhighout, MDRout, or any rout_sel bit is high in any cycle.
REQ-022 SHALL sample run only at instruction boundaries (IDLE and completion); run dropping mid-instruction SHALL NOT abort it.
REQ-023 SHALL ignore mem_rdy in every state except T1.

Reset
REQ-024 SHALL, while clr=0, force state IDLE, instr_count 0, illegal 0, and all strobes, alu_op, rout_sel, rin_sel 0 immediately, regardless of clk; an instruction in flight is discarded, and the first rising clk after release with run=1 enters T0.

Configuration
REQ-025 SHALL support macro CTRL_SEQ_MULDIV_EN: when defined, opcodes 01111 (MUL) and 10000 (DIV) are legal; T5 asserts Zlowout and LOin, T6 asserts Zhighout and HIin, and completion occurs after T6. When undefined, T6 is unreachable, LOin/HIin/Zhighout are tied 0, and both opcodes follow REQ-017.

Verification
REQ-026 SHALL verify: release clr, run=1, mem_rdy=1, ir=0x28918000 (AND R1,R2,R3) -> T0..T5 in 6 clocks; T3 rout_sel=0x0004; T4 rout_sel=0x0008 and alu_op=3; T5 rin_sel=0x0002; instr_count=1.
REQ-027 SHALL verify: mem_rdy held 0 for 3 cycles in T1 -> T1 lasts 4 cycles with PCin high only in the first; T2 follows the mem_rdy=1 cycle.
REQ-028 SHALL verify: ir=0xF8000000 (opcode 11111) -> illegal pulses 1 cycle in T3; no rin_sel activity; instr_count unchanged; next state T0.
REQ-029 SHALL verify: clr driven 0 mid-T4 between clock edges -> all outputs 0 and busy 0 before the next clk edge; instr_count=0.
REQ-030 SHALL verify: run dropped during T3 of OR (ir=0x30918000) -> instruction completes with alu_op=4 in T4, then IDLE; busy=0.
REQ-031 SHALL verify: with CTRL_SEQ_MULDIV_EN, ir=0x78918000 (MUL) -> alu_op=5 in T4; LOin in T5; Zhighout and HIin in T6; completion after T6. Without it, the same ir -> illegal pulse.
